// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-prediction pattern history table.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic {StInit, StReady} pht_state_e;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CTR_ST) ? c : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == CTR_SNT) ? c : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pht_array.sv
// Counter storage: one combinational read port, one synchronous write port, no reset.
module pht_array
  import bp_pkg::*;
#(
  parameter int unsigned IdxW = 8
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  ctr_t            wdata_i,
  input  logic [IdxW-1:0] raddr_i,
  output ctr_t            rdata_o
);

  localparam int unsigned Entries = 1 << IdxW;

  ctr_t mem_q [Entries];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pht_predictor.sv
// Pattern history table of 2-bit counters indexed by {pc_idx, hist}; registered prediction,
// read-modify-write update with write-first forwarding, and a clear sweep after reset.
module pht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_IDX_BITS = 4,
  parameter int unsigned HIST_WIDTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pred_req_i,
  input  logic [PC_IDX_BITS-1:0] pred_pc_idx_i,
  input  logic [HIST_WIDTH-1:0]  pred_hist_i,
  output logic                   pred_valid_o,
  output logic                   pred_taken_o,
  output logic [1:0]             pred_ctr_o,
  input  logic                   upd_valid_i,
  input  logic [PC_IDX_BITS-1:0] upd_pc_idx_i,
  input  logic [HIST_WIDTH-1:0]  upd_hist_i,
  input  logic                   upd_taken_i,
  output logic                   init_busy_o
);

  localparam int unsigned IDX_W   = PC_IDX_BITS + HIST_WIDTH;
  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

  pht_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             pred_valid_q, pred_taken_q, init_busy_q;
  ctr_t             pred_ctr_q;

  logic [IDX_W-1:0] pred_idx, upd_idx, waddr;
  ctr_t             pred_rd, upd_rd, upd_new, wdata, fwd_ctr;
  logic             we;

  assign pred_idx = {pred_pc_idx_i, pred_hist_i};
  assign upd_idx  = {upd_pc_idx_i, upd_hist_i};

  always_comb begin
    upd_new = upd_taken_i ? sat_inc(upd_rd) : sat_dec(upd_rd);
    we      = 1'b0;
    waddr   = upd_idx;
    wdata   = upd_new;
    if (!rst_i) begin
      if (state_q == StInit) begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = CTR_WNT;
      end else if (upd_valid_i) begin
        we = 1'b1;
      end
    end
    // Write-first: a same-cycle update to the predicted entry is visible to the prediction.
    fwd_ctr = (upd_valid_i && (upd_idx == pred_idx)) ? upd_new : pred_rd;
  end

  // Two identically written banks so predict and update each get a private read port.
  pht_array #(.IdxW(IDX_W)) u_bank_pred (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (pred_idx),
    .rdata_o (pred_rd)
  );

  pht_array #(.IdxW(IDX_W)) u_bank_upd (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (upd_idx),
    .rdata_o (upd_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StInit;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= CTR_WNT;
      init_busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          ptr_q        <= ptr_q + 1'b1;
          pred_valid_q <= 1'b0;
          if (ptr_q == LastIdx) begin
            state_q     <= StReady;
            init_busy_q <= 1'b0;
          end
        end
        StReady: begin
          pred_valid_q <= pred_req_i;
          if (pred_req_i) begin
            pred_ctr_q   <= fwd_ctr;
            pred_taken_q <= fwd_ctr[1];
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_ctr_o   = pred_ctr_q;
  assign init_busy_o  = init_busy_q;

endmodule

// File: tb/tb_pht_predictor.sv
// Self-checking bench for pht_predictor: directed vector table, reset sweeps, random vs model.
module tb_pht_predictor;

  localparam int PcBits  = 4;
  localparam int HistW   = 4;
  localparam int Entries = 1 << (PcBits + HistW);

  logic             clk = 1'b0;
  logic             rst;
  logic             pred_req;
  logic [PcBits-1:0] pred_pc_idx;
  logic [HistW-1:0] pred_hist;
  logic             pred_valid, pred_taken;
  logic [1:0]       pred_ctr;
  logic             upd_valid;
  logic [PcBits-1:0] upd_pc_idx;
  logic [HistW-1:0] upd_hist;
  logic             upd_taken;
  logic             init_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pht_predictor #(.PC_IDX_BITS(PcBits), .HIST_WIDTH(HistW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pred_req_i    (pred_req),
    .pred_pc_idx_i (pred_pc_idx),
    .pred_hist_i   (pred_hist),
    .pred_valid_o  (pred_valid),
    .pred_taken_o  (pred_taken),
    .pred_ctr_o    (pred_ctr),
    .upd_valid_i   (upd_valid),
    .upd_pc_idx_i  (upd_pc_idx),
    .upd_hist_i    (upd_hist),
    .upd_taken_i   (upd_taken),
    .init_busy_o   (init_busy)
  );

  typedef struct packed {
    logic       req;
    logic [3:0] pc;
    logic [3:0] hist;
    logic       upd;
    logic [3:0] upc;
    logic [3:0] uhist;
    logic       utaken;
    logic       exp_valid;
    logic [1:0] exp_ctr;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input int pc, input int h,
                       input logic upd, input int upc, input int uh, input logic ut);
    pred_req    = req;
    pred_pc_idx = PcBits'(pc);
    pred_hist   = HistW'(h);
    upd_valid   = upd;
    upd_pc_idx  = PcBits'(upc);
    upd_hist    = HistW'(uh);
    upd_taken   = ut;
  endtask

  // One-cycle reset with pred_req (and a stray update) held high; measures the busy window.
  task automatic reset_and_sweep(input string name);
    int n;
    int bad_valid;
    drive(1'b1, 3, 5, 1'b1, 0, 0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check({name, " rst valid"}, int'(pred_valid), 0);
    check({name, " rst ctr"}, int'(pred_ctr), 1);
    check({name, " rst taken"}, int'(pred_taken), 0);
    check({name, " rst busy"}, int'(init_busy), 1);
    n = 1;
    bad_valid = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!init_busy) break;
      n++;
      if (pred_valid) bad_valid++;
    end
    check({name, " busy cycles"}, n, Entries);
    check({name, " valid during sweep"}, bad_valid, 0);
    drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  vec_t vq[$];
  int   model[Entries];
  logic [1:0] last_ctr;

  initial begin
    rst = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    tick();

    reset_and_sweep("sweep0");
    drive(1'b1, 9, 12, 1'b0, 0, 0, 1'b0);
    tick();
    check("first pred valid", int'(pred_valid), 1);
    check("first pred ctr", int'(pred_ctr), 1);
    check("first pred taken", int'(pred_taken), 0);

    //                 req pc  h   upd upc uh  ut  ev  ectr
    vq.push_back({1'b0, 4'd3, 4'hA, 1'b1, 4'd3, 4'hA, 1'b1, 1'b0, 2'b00});
    vq.push_back({1'b1, 4'd3, 4'hA, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b10});
    vq.push_back({1'b0, 4'd3, 4'hA, 1'b1, 4'd3, 4'hA, 1'b1, 1'b0, 2'b00});
    vq.push_back({1'b1, 4'd3, 4'hA, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b11});
    vq.push_back({1'b0, 4'd3, 4'hA, 1'b1, 4'd3, 4'hA, 1'b1, 1'b0, 2'b00});
    vq.push_back({1'b1, 4'd3, 4'hA, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b11});
    vq.push_back({1'b0, 4'd0, 4'h0, 1'b1, 4'd0, 4'h0, 1'b0, 1'b0, 2'b00});
    vq.push_back({1'b0, 4'd0, 4'h0, 1'b1, 4'd0, 4'h0, 1'b0, 1'b0, 2'b00});
    vq.push_back({1'b1, 4'd0, 4'h0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b00});
    vq.push_back({1'b0, 4'd0, 4'h0, 1'b1, 4'd0, 4'h0, 1'b0, 1'b0, 2'b00});
    vq.push_back({1'b1, 4'd0, 4'h0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b00});
    vq.push_back({1'b1, 4'd5, 4'h3, 1'b1, 4'd5, 4'h3, 1'b1, 1'b1, 2'b10});
    vq.push_back({1'b0, 4'd0, 4'h0, 1'b1, 4'd1, 4'hF, 1'b1, 1'b0, 2'b00});
    vq.push_back({1'b0, 4'd0, 4'h0, 1'b1, 4'd1, 4'hF, 1'b1, 1'b0, 2'b00});
    vq.push_back({1'b1, 4'd1, 4'hF, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b11});
    vq.push_back({1'b1, 4'd1, 4'hE, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b01});
    vq.push_back({1'b1, 4'd2, 4'hF, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b01});
    vq.push_back({1'b1, 4'd6, 4'h6, 1'b1, 4'd7, 4'h7, 1'b0, 1'b1, 2'b01});
    vq.push_back({1'b1, 4'd7, 4'h7, 1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 2'b00});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].req, int'(vq[i].pc), int'(vq[i].hist), vq[i].upd, int'(vq[i].upc),
            int'(vq[i].uhist), vq[i].utaken);
      tick();
      check($sformatf("vec%0d valid", i), int'(pred_valid), int'(vq[i].exp_valid));
      if (vq[i].exp_valid) begin
        check($sformatf("vec%0d ctr", i), int'(pred_ctr), int'(vq[i].exp_ctr));
        check($sformatf("vec%0d taken", i), int'(pred_taken), int'(vq[i].exp_ctr[1]));
      end
    end

    // Random traffic on a fresh table against an array-of-counters model.
    reset_and_sweep("sweep1");
    for (int e = 0; e < Entries; e++) model[e] = 1;
    last_ctr = 2'b01;
    for (int c = 0; c < 2000; c++) begin
      int pidx, uidx, exp_ctr;
      logic req, upd, ut;
      req  = ($urandom_range(0, 3) != 0);
      upd  = ($urandom_range(0, 2) != 0);
      ut   = ($urandom_range(0, 99) < 60);
      pidx = ($urandom_range(0, 3) << HistW) | $urandom_range(0, 3);
      uidx = ($urandom_range(0, 2) == 0) ? pidx : (($urandom_range(0, 3) << HistW) | $urandom_range(0, 3));
      drive(req, pidx >> HistW, pidx % (1 << HistW), upd, uidx >> HistW,
            uidx % (1 << HistW), ut);
      if (upd) begin
        if (ut) model[uidx] = (model[uidx] == 3) ? 3 : model[uidx] + 1;
        else    model[uidx] = (model[uidx] == 0) ? 0 : model[uidx] - 1;
      end
      exp_ctr = req ? model[pidx] : int'(last_ctr);
      tick();
      check("rand valid", int'(pred_valid), int'(req));
      check("rand ctr", int'(pred_ctr), exp_ctr);
      check("rand taken", int'(pred_taken), exp_ctr / 2);
      last_ctr = 2'(exp_ctr);
    end

    // Saturate a few entries, then reset in READY and again 100 cycles into the sweep.
    for (int k = 0; k < 3; k++) begin
      for (int e = 0; e < 8; e++) begin
        drive(1'b0, 0, 0, 1'b1, e, 15 - e, 1'b1);
        tick();
      end
    end
    drive(1'b1, 0, 15, 1'b0, 0, 0, 1'b0);
    tick();
    check("pre-reset ctr", int'(pred_ctr), 3);
    drive(1'b1, 0, 0, 1'b1, 2, 13, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 99; c++) tick();
    check("mid sweep busy", int'(init_busy), 1);
    reset_and_sweep("sweep2");
    for (int e = 0; e < Entries; e++) begin
      drive(1'b1, e >> HistW, e % (1 << HistW), 1'b0, 0, 0, 1'b0);
      tick();
      check($sformatf("clear entry %0d", e), int'(pred_ctr), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pht_predictor.md
Name: pht_predictor

Overview:
- Consumer side of the branch history table. It takes a per-branch history pattern, read from the BHT, together with PC index bits.
- It indexes a pattern history table of 2-bit saturating counters and returns a registered taken/not-taken prediction to fetch.
- On branch resolution it updates the addressed counter. The same history the BHT supplies on its write-side read port forms the update index.
- After reset it sweeps the whole table to the weakly-not-taken value before accepting traffic.

Parameters:
- PC_IDX_BITS, 4, number of PC bits used in the table index
- HIST_WIDTH, 4, width of the history pattern; matches the BHT entry width
- Derived, not overridable: IDX_W = PC_IDX_BITS + HIST_WIDTH; ENTRIES = 2**IDX_W (256 at defaults)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- pred_req  in  1  fetch requests a prediction this cycle
- pred_pc_idx  in  PC_IDX_BITS  PC index bits of the fetched branch
- pred_hist  in  HIST_WIDTH  history pattern for the fetched branch (BHT read port)
- pred_valid  out  1  pred_taken/pred_ctr are valid this cycle
- pred_taken  out  1  predicted direction (counter MSB)
- pred_ctr  out  2  raw counter value used for the prediction
- upd_valid  in  1  resolved branch update this cycle
- upd_pc_idx  in  PC_IDX_BITS  PC index bits of the resolved branch
- upd_hist  in  HIST_WIDTH  history at prediction time (BHT write-side read port, pre-shift)
- upd_taken  in  1  actual resolved direction
- init_busy  out  1  table clear sweep in progress

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Index: {pc_idx, hist}, with pc_idx in the upper bits. The same rule applies to both the predict and update paths.
- FSM states: INIT and READY.
  - rst=1 at a clock edge: state<=INIT, sweep pointer<=0, pred_valid<=0, pred_taken<=0, pred_ctr<=2'b01, init_busy<=1.
  - INIT: each cycle writes 2'b01 to entry[ptr] and increments ptr. When the write to entry ENTRIES-1 completes, state<=READY and init_busy<=0.
  - The sweep takes exactly ENTRIES cycles after reset deasserts (256 at defaults).
  - In INIT, pred_req is ignored (pred_valid stays 0) and upd_valid is dropped; neither is queued.
  - rst asserted mid-sweep restarts the sweep at pointer 0.
- READY, predict path:
  - Latency is 1 cycle: pred_valid(t+1) = pred_req(t).
  - pred_ctr(t+1) = counter at the cycle-t index; pred_taken = pred_ctr[1].
  - When pred_req=0, pred_valid<=0 and pred_taken/pred_ctr hold their previous values.
- READY, update path: single-cycle read-modify-write at the edge.
  - upd_taken=1: saturating increment (11 stays 11).
  - upd_taken=0: saturating decrement (00 stays 00).
- Collision: predict and update to the same index in the same cycle gives write-first forwarding. The prediction returned is the post-update counter value.
- Back-to-back updates to the same index apply cumulatively, one step per cycle, with no lost updates.
- Predict and update to different indices in the same cycle are independent.
- No backpressure: every READY-state request yields a response on the next cycle.

Decomposition:
- Package bp_pkg:
  - typedef ctr_t (logic [1:0])
  - constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
  - functions sat_inc and sat_dec on ctr_t
  - enum for the INIT/READY states
- Sub-module pht_array holds only the storage and the FSM stays in the top:
  - ENTRIES x ctr_t storage
  - one combinational read port
  - one synchronous write port
  - no reset on the array itself

Test Plan:
- Reset sweep: pulse rst for 1 cycle, hold pred_req=1 throughout → init_busy=1 for exactly 256 cycles and pred_valid=0 during that window. The first prediction after READY returns pred_ctr=01, pred_taken=0 for any index.
- Saturate up: in READY, three upd_valid with upd_taken=1 at pc_idx=3, hist=4'b1010 → a predict at the same index returns pred_ctr 10, 11, 11 after updates 1, 2 and 3; pred_taken=1.
- Saturate down: two updates with upd_taken=0 at pc_idx=0, hist=0 → pred_ctr=00. A third not-taken update keeps it at 00.
- Collision forwarding: entry {5,4'b0011}=01; in one cycle apply pred_req and upd_valid/upd_taken=1 to that same index → next cycle pred_valid=1, pred_ctr=10, pred_taken=1.
- Index isolation: update {1,4'b1111} to 11, then predict {1,4'b1110} and {2,4'b1111} → both return 01.
- Reset mid-operation: set several entries to 11, assert rst during READY, then again 100 cycles into the sweep → init_busy lasts 256 cycles from the last rst, and every entry reads 01 afterwards.
